// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    COIN_5   = 2'b00,
    COIN_10  = 2'b01,
    COIN_25  = 2'b10,
    COIN_BAD = 2'b11
  } coin_t;

  localparam int unsigned COIN_VAL_W  = 5;
  localparam int unsigned CHANGE_UNIT = 5;

  // Face value of a coin in credit units; an invalid coin is worth nothing.
  function automatic logic [COIN_VAL_W-1:0] coin_value(input coin_t t);
    case (t)
      COIN_5:  coin_value = COIN_VAL_W'(5);
      COIN_10: coin_value = COIN_VAL_W'(10);
      COIN_25: coin_value = COIN_VAL_W'(25);
      default: coin_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-product stock counters: bulk load, single decrement, zero flags.
module vend_stock_bank #(
  parameter int unsigned NUM_PROD   = 4,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic                        dec,
  input  logic [$clog2(NUM_PROD)-1:0] dec_idx,
  output logic [NUM_PROD-1:0]         zero_c
);

  localparam int unsigned IDX_W = $clog2(NUM_PROD);

  logic [STOCK_W-1:0] cnt [NUM_PROD];

  // Load wins over decrement; counters stop at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PROD; p++) cnt[p] <= STOCK_W'(STOCK_INIT);
    end else if (load) begin
      for (int p = 0; p < NUM_PROD; p++) cnt[p] <= STOCK_W'(STOCK_INIT);
    end else if (dec) begin
      for (int p = 0; p < NUM_PROD; p++) begin
        if (dec_idx == IDX_W'(p) && cnt[p] != '0) cnt[p] <= cnt[p] - STOCK_W'(1);
      end
    end
  end

  // Empty flag per product.
  always_comb begin
    zero_c = '0;
    for (int p = 0; p < NUM_PROD; p++) zero_c[p] = (cnt[p] == '0);
  end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised N-product vending controller: credit FSM and registered outputs.
module vending_machine_param
  import vend_pkg::*;
#(
  parameter int unsigned                 NUM_PROD   = 4,
  parameter int unsigned                 CREDIT_W   = 8,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES    = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int unsigned                 MAX_CREDIT = 100,
  parameter int unsigned                 STOCK_W    = 4,
  parameter int unsigned                 STOCK_INIT = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        coin_valid,
  input  logic [1:0]                  coin_type,
  input  logic                        sel_valid,
  input  logic [$clog2(NUM_PROD)-1:0] sel_idx,
  input  logic                        cancel,
  input  logic                        restock,
  output logic                        dispense,
  output logic [$clog2(NUM_PROD)-1:0] dispense_idx,
  output logic                        change_pulse,
  output logic                        coin_reject,
  output logic                        insufficient,
  output logic                        sold_out,
  output logic [CREDIT_W-1:0]         credit,
  output logic                        busy
);

  localparam int unsigned IDX_W = $clog2(NUM_PROD);
  localparam int unsigned SUM_W = CREDIT_W + 1;

  state_t               state, state_n;
  logic [CREDIT_W-1:0]  credit_n;
  logic [IDX_W-1:0]     idx_n;
  logic                 dispense_n, change_n, reject_n, insuf_n, sold_n, busy_n;
  logic                 stock_dec;
  logic [NUM_PROD-1:0]  stock_zero_c;
  logic [SUM_W-1:0]     sum;

  // Price lookup that yields 0 for an out-of-range index.
  function automatic logic [CREDIT_W-1:0] price_of(input logic [IDX_W-1:0] i);
    price_of = '0;
    for (int p = 0; p < NUM_PROD; p++)
      if (i == IDX_W'(p)) price_of = PRICES[p*CREDIT_W +: CREDIT_W];
  endfunction

  // Out-of-range products read as empty.
  function automatic logic empty_at(input logic [IDX_W-1:0] i, input logic [NUM_PROD-1:0] z);
    empty_at = 1'b1;
    for (int p = 0; p < NUM_PROD; p++)
      if (i == IDX_W'(p)) empty_at = z[p];
  endfunction

  vend_stock_bank #(
    .NUM_PROD  (NUM_PROD),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT)
  ) u_stock (
    .clk    (clk),
    .reset  (reset),
    .load   (restock),
    .dec    (stock_dec),
    .dec_idx(dispense_idx),
    .zero_c (stock_zero_c)
  );

  // State, credit and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= '0;
      dispense     <= 1'b0;
      dispense_idx <= '0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      sold_out     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      dispense     <= dispense_n;
      dispense_idx <= idx_n;
      change_pulse <= change_n;
      coin_reject  <= reject_n;
      insufficient <= insuf_n;
      sold_out     <= sold_n;
      busy         <= busy_n;
    end
  end

  // Next state and next outputs; cancel beats select beats coin.
  always_comb begin
    state_n   = state;
    credit_n  = credit;
    idx_n     = dispense_idx;
    reject_n  = 1'b0;
    insuf_n   = 1'b0;
    sold_n    = 1'b0;
    stock_dec = 1'b0;
    sum       = {1'b0, credit} + SUM_W'(coin_value(coin_t'(coin_type)));

    case (state)
      IDLE, CREDIT: begin
        if (cancel && state == CREDIT) begin
          state_n  = CHANGE;
          reject_n = coin_valid;
        end else if (sel_valid) begin
          reject_n = coin_valid;
          if (empty_at(sel_idx, stock_zero_c)) begin
            sold_n = 1'b1;
          end else if (credit < price_of(sel_idx)) begin
            insuf_n = 1'b1;
          end else begin
            state_n = VEND;
            idx_n   = sel_idx;
          end
        end else if (coin_valid) begin
          if (coin_t'(coin_type) != COIN_BAD && sum <= SUM_W'(MAX_CREDIT)) begin
            credit_n = sum[CREDIT_W-1:0];
            state_n  = CREDIT;
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      VEND: begin
        credit_n  = credit - price_of(dispense_idx);
        stock_dec = 1'b1;
        state_n   = (credit_n != '0) ? CHANGE : IDLE;
        reject_n  = coin_valid;
      end
      CHANGE: begin
        credit_n = credit - CREDIT_W'(CHANGE_UNIT);
        state_n  = (credit_n == '0) ? IDLE : CHANGE;
        reject_n = coin_valid;
      end
      default: state_n = IDLE;
    endcase

    dispense_n = (state_n == VEND);
    change_n   = (state_n == CHANGE);
    busy_n     = (state_n == VEND) || (state_n == CHANGE);
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param with default parameters.
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid, sel_valid, cancel, restock;
  logic [1:0] coin_type;
  logic [1:0] sel_idx;
  logic       dispense, change_pulse, coin_reject, insufficient, sold_out, busy;
  logic [1:0] dispense_idx;
  logic [7:0] credit;

  int n_checks = 0;
  int n_pass   = 0;

  vending_machine_param dut (
    .clk         (clk),
    .reset       (reset),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .sel_valid   (sel_valid),
    .sel_idx     (sel_idx),
    .cancel      (cancel),
    .restock     (restock),
    .dispense    (dispense),
    .dispense_idx(dispense_idx),
    .change_pulse(change_pulse),
    .coin_reject (coin_reject),
    .insufficient(insufficient),
    .sold_out    (sold_out),
    .credit      (credit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [1:0] i);
    sel_valid = 1'b1;
    sel_idx   = i;
    step();
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  // Count change pulses from the current cycle until the machine is idle.
  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (change_pulse) n++;
      if (!busy && !change_pulse) break;
      step();
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; sel_valid = 1'b0;
    sel_idx = 2'd0; cancel = 1'b0; restock = 1'b0;
    #22;
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_change", change_pulse, 0);
    reset = 1'b0;
    step();

    // 10+10, buy product 1 (15), 5 back
    put_coin(2'b01); chk("t1_c10", credit, 10);
    put_coin(2'b01); chk("t1_c20", credit, 20);
    select(2'd1);
    chk("t1_disp", dispense, 1); chk("t1_idx", dispense_idx, 1);
    chk("t1_busy", busy, 1);     chk("t1_cr_vend", credit, 20);
    step();
    chk("t1_pulse", change_pulse, 1); chk("t1_cr5", credit, 5);
    chk("t1_disp_off", dispense, 0);
    step();
    chk("t1_pulse_off", change_pulse, 0); chk("t1_cr0", credit, 0);
    chk("t1_idle", busy, 0);

    // insufficient then cancel
    put_coin(2'b00); chk("t2_c5", credit, 5);
    select(2'd0);
    chk("t2_insuf", insufficient, 1); chk("t2_cr", credit, 5);
    chk("t2_nodisp", dispense, 0);
    do_cancel(); drain(n);
    chk("t2_pulses", n, 1); chk("t2_cr0", credit, 0);

    // ceiling and bad coin
    put_coin(2'b10); put_coin(2'b10); put_coin(2'b10);
    put_coin(2'b01); put_coin(2'b01);
    chk("t3_cr95", credit, 95);
    put_coin(2'b01); chk("t3_rej10", coin_reject, 1); chk("t3_cr95b", credit, 95);
    put_coin(2'b00); chk("t3_acc5", coin_reject, 0); chk("t3_cr100", credit, 100);
    put_coin(2'b11); chk("t3_rejbad", coin_reject, 1); chk("t3_cr100b", credit, 100);
    do_cancel(); drain(n);
    chk("t3_pulses", n, 20); chk("t3_cr0", credit, 0);

    // product 2 (20) three times, then sold out, restock
    for (int k = 0; k < 3; k++) begin
      put_coin(2'b01); put_coin(2'b01);
      select(2'd2);
      chk("t4_disp", dispense, 1); chk("t4_idx", dispense_idx, 2);
      step();
      chk("t4_cr0", credit, 0); chk("t4_idle", busy, 0);
    end
    put_coin(2'b10);
    select(2'd2);
    chk("t4_sold", sold_out, 1); chk("t4_nodisp", dispense, 0);
    chk("t4_keep", credit, 25);
    restock = 1'b1; step(); restock = 1'b0;
    select(2'd2);
    chk("t4_restock_disp", dispense, 1);
    step(); drain(n);
    chk("t4_pulses", n, 1); chk("t4_cr0b", credit, 0);

    // coin during change
    put_coin(2'b10);
    do_cancel();
    chk("t5_p1", change_pulse, 1);
    coin_valid = 1'b1; coin_type = 2'b01;
    step();
    coin_valid = 1'b0;
    chk("t5_rej", coin_reject, 1); chk("t5_cr", credit, 20);
    drain(n);
    chk("t5_rest", n, 4); chk("t5_cr0", credit, 0);

    // select + cancel + coin in the same cycle
    put_coin(2'b01);
    sel_valid = 1'b1; sel_idx = 2'd0; cancel = 1'b1; coin_valid = 1'b1; coin_type = 2'b10;
    step();
    sel_valid = 1'b0; cancel = 1'b0; coin_valid = 1'b0;
    chk("t5_rej2", coin_reject, 1); chk("t5_nodisp", dispense, 0);
    drain(n);
    chk("t5_refund", n, 2); chk("t5_cr0b", credit, 0);

    // reset in the middle of a change train
    put_coin(2'b10); put_coin(2'b10);
    select(2'd0);
    chk("t6_disp", dispense, 1);
    step(); chk("t6_cr40", credit, 40);
    step(); step();
    chk("t6_p3", change_pulse, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_pulse", change_pulse, 0); chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cr", credit, 0);
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      put_coin(2'b01); put_coin(2'b01);
      select(2'd2);
      chk("t6_buy", dispense, 1);
      step();
    end
    put_coin(2'b00);
    select(2'd2);
    chk("t6_sold", sold_out, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
